// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-port SRAM arbiter.
// Widths match the SRAM1RW256x46 macro.
package sram_arb_pkg;

  localparam int SRAM_ADDR_W = 8;
  localparam int SRAM_DATA_W = 46;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  typedef logic port_id_t;

  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/sram_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
// Ports: clock, reset_n, valid[1:0], accept in; grant[1:0] out.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  // Resets to 1 so port 0 wins the first tie.
  port_id_t last_grant;

  always_comb begin
    grant = valid;
    if (&valid) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM macro between two requesters.
// Ports: clock, reset_n; req0_*/req1_* valid/ready/we/addr/wdata;
//   rsp_valid/rsp_id/rsp_data read return; busy during init;
//   sram_csb/web/oeb (active-low), sram_a, sram_i, sram_o to the macro.
// Optional macro SRAM_INIT_EN: zero-fill the macro after reset.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_i,
  input  logic [DATA_W-1:0] sram_o
);

  logic run;
  logic init;
  logic [1:0] grant;
  logic accept;
  port_id_t sel;
  logic sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef SRAM_INIT_EN
  state_e state_q;
  state_e state_d;
  logic [ADDR_W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT: if (&cnt_q) state_d = RUN;
      RUN:  state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Gate with reset_n so the macro is released the
  // instant reset asserts, not at the next edge.
  assign run  = reset_n & (state_q == RUN);
  assign init = reset_n & (state_q == INIT);
  assign busy = (state_q == INIT);
`else
  assign run  = reset_n;
  assign init = 1'b0;
  assign busy = 1'b0;
`endif

  rr_arb2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .valid   ({req1_valid, req0_valid} & {2{run}}),
    .accept  (accept),
    .grant   (grant)
  );

  // Grant only ever covers valid ports, so any grant is an accept.
  assign accept     = |grant;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign sel       = grant[1];
  assign sel_we    = sel ? req1_we    : req0_we;
  assign sel_addr  = sel ? req1_addr  : req0_addr;
  assign sel_wdata = sel ? req1_wdata : req0_wdata;

  always_comb begin
    sram_csb = 1'b1;
    sram_web = 1'b1;
    sram_oeb = 1'b1;
    sram_a   = sel_addr;
    sram_i   = sel_wdata;
`ifdef SRAM_INIT_EN
    if (init) begin
      sram_csb = 1'b0;
      sram_web = 1'b0;
      sram_a   = cnt_q;
      sram_i   = '0;
    end else
`endif
    if (accept) begin
      sram_csb = 1'b0;
      sram_web = ~sel_we;
      sram_oeb = sel_we;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
    end else begin
      rsp_valid <= accept & ~sel_we;
      if (accept & ~sel_we) begin
        rsp_id <= sel;
      end
    end
  end

  // Macro output register already holds the data in cycle k+1.
  assign rsp_data = sram_o;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural macro.
// Builds with or without SRAM_INIT_EN.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 46;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic req0_valid = 0, req0_we = 0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic req1_valid = 0, req1_we = 0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic req0_ready, req1_ready;
  logic rsp_valid, rsp_id, busy;
  logic [DW-1:0] rsp_data;
  logic sram_csb, sram_web, sram_oeb;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_i, sram_o;

  sram_port_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy),
    .sram_csb(sram_csb), .sram_web(sram_web),
    .sram_oeb(sram_oeb), .sram_a(sram_a),
    .sram_i(sram_i), .sram_o(sram_o)
  );

  always #5 clock = ~clock;

  // Behavioural macro: junk contents, 1-cycle registered read.
  logic [DW-1:0] mem [256];
  bit filled = 1'b0;
  always @(posedge clock) begin
    if (!filled) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= 46'h2A5A_5A5A_C3C3 ^ DW'(i);
      filled <= 1'b1;
    end else if (!sram_csb) begin
      if (!sram_web) mem[sram_a] <= sram_i;
      if (!sram_oeb) sram_o <= mem[sram_a];
    end
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit rst;
    bit v0; bit we0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    bit v1; bit we1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic [1:0] gnt;
  } vec_t;

  typedef struct {
    bit id;
    bit kn;
    logic [DW-1:0] d;
  } rsp_t;

  logic [DW-1:0] mdl [256];
  bit known [256];
  rsp_t q[$];
  vec_t tbl[25];

  function automatic vec_t mk(
    bit rst, bit v0, bit we0, logic [AW-1:0] a0,
    logic [DW-1:0] d0, bit v1, bit we1,
    logic [AW-1:0] a1, logic [DW-1:0] d1, logic [1:0] g);
    vec_t v;
    v.rst = rst;
    v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.gnt = g;
    return v;
  endfunction

  task automatic idle_inputs();
    req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
  endtask

  task automatic check_in_reset();
    chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
    chk("rst_ctrl", {sram_csb, sram_web, sram_oeb}, 3'b111);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, 1'b0);
`ifdef SRAM_INIT_EN
    chk("rst_busy", busy, 1'b1);
`else
    chk("rst_busy", busy, 1'b0);
`endif
  endtask

  task automatic release_reset();
    int n;
    bit rdy_seen;
    repeat (2) @(posedge clock);
    @(negedge clock);
    idle_inputs();
    reset_n = 1'b1;
    q.delete();
`ifdef SRAM_INIT_EN
    // Hold a request during the sweep; it must not be granted.
    req0_valid = 1'b1;
    n = 0;
    rdy_seen = 0;
    #1;
    while (busy && n < 400) begin
      if (req0_ready) rdy_seen = 1;
      @(posedge clock);
      #1;
      n++;
    end
    req0_valid = 1'b0;
    chk("init_busy_cycles", 64'(n), 64'd256);
    chk("init_ready_held_low", 64'(rdy_seen), 64'd0);
    for (int i = 0; i < 256; i++) begin
      mdl[i] = '0;
      known[i] = 1;
    end
`else
    #1;
    chk("run_busy", busy, 1'b0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_in_reset();
    release_reset();
  endtask

  task automatic check_rsp();
    rsp_t r;
    if (q.size() > 0) begin
      r = q.pop_front();
      chk("rsp_valid", rsp_valid, 1'b1);
      chk("rsp_id", rsp_id, r.id);
      if (r.kn) chk("rsp_data", rsp_data, r.d);
    end else begin
      chk("rsp_idle", rsp_valid, 1'b0);
    end
  endtask

  task automatic apply(vec_t v);
    bit acc, sel, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (v.rst) do_reset();
    @(negedge clock);
    req0_valid = v.v0; req0_we = v.we0;
    req0_addr = v.a0; req0_wdata = v.d0;
    req1_valid = v.v1; req1_we = v.we1;
    req1_addr = v.a1; req1_wdata = v.d1;
    #1;
    acc = |v.gnt;
    sel = v.gnt[1];
    we = sel ? v.we1 : v.we0;
    a = sel ? v.a1 : v.a0;
    d = sel ? v.d1 : v.d0;
    chk("ready", {req1_ready, req0_ready}, v.gnt);
    chk("ctrl", {sram_csb, sram_web, sram_oeb},
        {!acc, !(acc && we), !(acc && !we)});
    if (acc) chk("sram_a", sram_a, a);
    if (acc && we) chk("sram_i", sram_i, d);
    @(posedge clock);
    if (acc) begin
      if (we) begin
        mdl[a] = d;
        known[a] = 1;
      end else begin
        q.push_back('{sel, known[a], mdl[a]});
      end
    end
    #1;
    check_rsp();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mdl[i] = '0;
      known[i] = 0;
    end
    // rst, v0 we0 a0 d0, v1 we1 a1 d1, expected grant
    tbl[0]  = mk(1, 1,1,8'h2A,46'h1234, 0,0,8'h00,0, 2'b01);
    tbl[1]  = mk(0, 1,0,8'h2A,0,        0,0,8'h00,0, 2'b01);
    tbl[2]  = mk(0, 0,0,8'h00,0, 1,1,8'hFF,46'h3FFF_FFFF_FFFF, 2'b10);
    tbl[3]  = mk(0, 1,0,8'hFF,0,        0,0,8'h00,0, 2'b01);
    tbl[4]  = mk(0, 1,1,8'h10,46'hAAA,  1,1,8'h11,46'hBBB, 2'b10);
    tbl[5]  = mk(0, 1,1,8'h10,46'hAAA,  1,1,8'h11,46'hBBB, 2'b01);
    tbl[6]  = mk(1, 1,0,8'h10,0,        1,0,8'h11,0, 2'b01);
    tbl[7]  = mk(0, 1,0,8'h10,0,        1,0,8'h11,0, 2'b10);
    tbl[8]  = mk(0, 1,0,8'h10,0,        1,0,8'h11,0, 2'b01);
    tbl[9]  = mk(0, 1,0,8'h10,0,        1,0,8'h11,0, 2'b10);
    tbl[10] = mk(0, 1,0,8'h2A,0,        1,1,8'h2A,46'h5555, 2'b01);
    tbl[11] = mk(0, 1,0,8'h2A,0,        1,1,8'h2A,46'h5555, 2'b10);
    tbl[12] = mk(0, 1,0,8'h2A,0,        0,0,8'h00,0, 2'b01);
    tbl[13] = mk(0, 0,0,8'h00,0,        0,0,8'h00,0, 2'b00);
    tbl[14] = mk(0, 1,0,8'h2A,0,        0,0,8'h00,0, 2'b01);
    tbl[15] = mk(0, 1,1,8'h20,46'h111,  0,0,8'h00,0, 2'b01);
    tbl[16] = mk(0, 1,0,8'h20,0,        0,0,8'h00,0, 2'b01);
    tbl[17] = mk(0, 1,1,8'h21,46'h222,  0,0,8'h00,0, 2'b01);
    tbl[18] = mk(0, 1,0,8'h21,0,        0,0,8'h00,0, 2'b01);
    tbl[19] = mk(0, 1,0,8'hFF,0,        0,0,8'h00,0, 2'b01);
    tbl[20] = mk(0, 0,0,8'h00,0,        0,0,8'h00,0, 2'b00);
    tbl[21] = mk(1, 1,0,8'h00,0,        0,0,8'h00,0, 2'b01);
    tbl[22] = mk(0, 1,0,8'h80,0,        0,0,8'h00,0, 2'b01);
    tbl[23] = mk(0, 1,0,8'hFF,0,        0,0,8'h00,0, 2'b01);
    tbl[24] = mk(0, 0,0,8'h00,0,        0,0,8'h00,0, 2'b00);

    // Power-on reset, checked while held.
    idle_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_in_reset();
    release_reset();

    for (int i = 0; i < 25; i++) apply(tbl[i]);

    // Reset while a read response is in flight.
    @(negedge clock);
    req0_valid = 1; req0_we = 0; req0_addr = 8'h2A;
    #1;
    chk("inflight_ready", {req1_ready, req0_ready}, 2'b01);
    @(posedge clock);
    #1;
    chk("inflight_rsp", rsp_valid, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    chk("midrst_ctrl", {sram_csb, sram_web, sram_oeb}, 3'b111);
    chk("midrst_ready", {req1_ready, req0_ready}, 2'b00);
    release_reset();

    // Back to normal traffic after the mid-op reset.
    apply(mk(0, 1,1,8'h33,46'h77, 0,0,8'h00,0, 2'b01));
    apply(mk(0, 0,0,8'h00,0, 1,0,8'h33,0, 2'b10));
    apply(mk(0, 0,0,8'h00,0, 0,0,8'h00,0, 2'b00));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
